riscv_lsu: RTL and testbench

//  Parametrised load/store unit replacing the single-cycle direct data-memory path of the core.

---
 rtl/riscv_lsu_pkg.sv | 33 +++
 rtl/riscv_lsu_lane.sv | 86 ++++++++
 rtl/riscv_lsu.sv | 220 ++++++++++++++++++++++
 tb/tb_riscv_lsu.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_lsu_pkg.sv
// Shared types for the load/store unit: access size and FSM state encodings,
// plus the size-legality helper used at request acceptance.
package riscv_lsu_pkg;

    typedef enum logic [1:0] {
        LSU_SIZE_B = 2'b00,
        LSU_SIZE_H = 2'b01,
        LSU_SIZE_W = 2'b10,
        LSU_SIZE_D = 2'b11
    } lsu_size_e;

    localparam int LSU_STATE_LEN = 2;

    typedef enum logic [LSU_STATE_LEN-1:0] {
        LSU_ST_IDLE = 2'b00,
        LSU_ST_BUS  = 2'b01,
        LSU_ST_RESP = 2'b10
    } lsu_state_e;

    // Doubleword does not exist on a 32-bit datapath, and LWU is pointless there
    // because a word already fills the register.
    function automatic logic size_illegal(input lsu_size_e size, input logic zext, input int xlen);
        logic bad;
        bad = 1'b0;
        if (xlen == 32) begin
            bad = (size == LSU_SIZE_D) || ((size == LSU_SIZE_W) && zext);
        end else begin
            bad = 1'b0;
        end
        return bad;
    endfunction

endpackage

// File: rtl/riscv_lsu_lane.sv
// Byte-lane steering for the LSU: builds byte enables and replicated store data,
// and extracts/extends load data. Purely combinational; the same instance serves
// the store path at acceptance and the load path at bus acknowledge.
module riscv_lsu_lane
    import riscv_lsu_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [$clog2(XLEN/8)-1:0] off,
    input  lsu_size_e                 size,
    input  logic                      zext,
    input  logic [XLEN-1:0]           wdata,
    input  logic [XLEN-1:0]           rdata,
    output logic [XLEN/8-1:0]         be,
    output logic [XLEN-1:0]           wdata_lane,
    output logic [XLEN-1:0]           rdata_ext
);

    localparam int NB = XLEN / 8;
    localparam logic [NB-1:0] BE_B = NB'(1'b1);
    localparam logic [NB-1:0] BE_H = NB'(2'b11);
    localparam logic [NB-1:0] BE_W = NB'(4'hF);

    logic [$clog2(XLEN/8)+2:0] shamt_s;
    logic [XLEN-1:0]           shifted_s;
    logic [XLEN-1:0]           mask_s;
    logic                      sign_s;

    // Byte enables: a contiguous group of lanes sized by the access, starting at off.
    always_comb begin
        be = '0;
        case (size)
            LSU_SIZE_B: be = BE_B << off;
            LSU_SIZE_H: be = BE_H << off;
            LSU_SIZE_W: be = BE_W << off;
            LSU_SIZE_D: be = '1;
            default:    be = '0;
        endcase
    end

    // Store data replicated across every lane so whichever lanes are enabled see it.
    always_comb begin
        wdata_lane = '0;
        case (size)
            LSU_SIZE_B: wdata_lane = {NB{wdata[7:0]}};
            LSU_SIZE_H: wdata_lane = {(NB/2){wdata[15:0]}};
            LSU_SIZE_W: wdata_lane = {(NB/4){wdata[31:0]}};
            LSU_SIZE_D: wdata_lane = wdata;
            default:    wdata_lane = '0;
        endcase
    end

    // Load data: shift the addressed lanes down, keep size bits, then fill the
    // upper bits with the size MSB unless zero-extending. A full-width mask leaves
    // nothing to extend, which covers W on 32-bit and D on 64-bit.
    always_comb begin
        shamt_s   = {off, 3'b000};
        shifted_s = rdata >> shamt_s;
        mask_s    = '0;
        sign_s    = 1'b0;
        case (size)
            LSU_SIZE_B: begin
                mask_s = XLEN'(8'hFF);
                sign_s = shifted_s[7];
            end
            LSU_SIZE_H: begin
                mask_s = XLEN'(16'hFFFF);
                sign_s = shifted_s[15];
            end
            LSU_SIZE_W: begin
                mask_s = XLEN'(32'hFFFF_FFFF);
                sign_s = shifted_s[31];
            end
            LSU_SIZE_D: begin
                mask_s = '1;
                sign_s = 1'b0;
            end
            default: begin
                mask_s = '0;
                sign_s = 1'b0;
            end
        endcase
        rdata_ext = (shifted_s & mask_s) | ((sign_s && !zext) ? ~mask_s : '0);
    end

endmodule

// File: rtl/riscv_lsu.sv
// Load/store unit between the execute stage and the io bridge. Accepts one
// access per handshake, drives a wait-state tolerant bus with a timeout, and
// returns extended load data with a one-cycle completion pulse.
// Build option: define LSU_MISALIGN_TRAP_EN to fault misaligned accesses
// instead of silently aligning them down.
module riscv_lsu
    import riscv_lsu_pkg::*;
#(
    parameter int XLEN    = 32,
    parameter int ADDR_W  = 32,
    parameter int TIMEOUT = 255
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic                req_we,
    input  logic [1:0]          req_size,
    input  logic                req_unsigned,
    input  logic [ADDR_W-1:0]   req_addr,
    input  logic [XLEN-1:0]     req_wdata,
    output logic                resp_valid,
    output logic [XLEN-1:0]     resp_rdata,
    output logic                resp_err,
    output logic                busy,
    output logic                bus_valid,
    output logic                bus_we,
    output logic [ADDR_W-1:0]   bus_addr,
    output logic [XLEN/8-1:0]   bus_be,
    output logic [XLEN-1:0]     bus_wdata,
    input  logic                bus_ack,
    input  logic [XLEN-1:0]     bus_rdata
);

    localparam int NB    = XLEN / 8;
    localparam int OFF_W = $clog2(NB);
    localparam int CNT_W = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    lsu_state_e        state_r;
    logic              req_ready_r;
    logic              we_r;
    lsu_size_e         size_r;
    logic              zext_r;
    logic [OFF_W-1:0]  off_r;
    logic [CNT_W-1:0]  tmo_cnt_r;
    logic              bus_valid_r;
    logic              busy_r;
    logic              bus_we_r;
    logic [ADDR_W-1:0] bus_addr_r;
    logic [NB-1:0]     bus_be_r;
    logic [XLEN-1:0]   bus_wdata_r;
    logic              resp_valid_r;
    logic [XLEN-1:0]   resp_rdata_r;
    logic              resp_err_r;

    lsu_size_e         size_in_s;
    logic [OFF_W-1:0]  off_raw_s;
    logic [OFF_W-1:0]  off_al_s;
    logic              illegal_s;
    logic              misalign_s;
    logic              fault_s;
    logic [OFF_W-1:0]  lane_off_s;
    lsu_size_e         lane_size_s;
    logic              lane_zext_s;
    logic [NB-1:0]     lane_be_s;
    logic [XLEN-1:0]   lane_wdata_s;
    logic [XLEN-1:0]   lane_rdata_s;

    assign size_in_s = lsu_size_e'(req_size);
    assign off_raw_s = req_addr[OFF_W-1:0];
    assign illegal_s = size_illegal(size_in_s, req_unsigned, XLEN);

    // Natural-alignment offset for the requested size (low bits below the size cleared).
    always_comb begin
        off_al_s = off_raw_s;
        case (size_in_s)
            LSU_SIZE_B: off_al_s = off_raw_s;
            LSU_SIZE_H: off_al_s = off_raw_s & ~OFF_W'(2'b01);
            LSU_SIZE_W: off_al_s = off_raw_s & ~OFF_W'(2'b11);
            LSU_SIZE_D: off_al_s = '0;
            default:    off_al_s = '0;
        endcase
    end

`ifdef LSU_MISALIGN_TRAP_EN
    assign misalign_s = (off_al_s != off_raw_s);
`else
    assign misalign_s = 1'b0;
`endif

    assign fault_s = illegal_s || misalign_s;

    // The lane unit sees the live request while idle and the latched access otherwise.
    always_comb begin
        if (state_r == LSU_ST_IDLE) begin
            lane_off_s  = off_al_s;
            lane_size_s = size_in_s;
            lane_zext_s = req_unsigned;
        end else begin
            lane_off_s  = off_r;
            lane_size_s = size_r;
            lane_zext_s = zext_r;
        end
    end

    riscv_lsu_lane #(
        .XLEN (XLEN)
    ) u_lane (
        .off        (lane_off_s),
        .size       (lane_size_s),
        .zext       (lane_zext_s),
        .wdata      (req_wdata),
        .rdata      (bus_rdata),
        .be         (lane_be_s),
        .wdata_lane (lane_wdata_s),
        .rdata_ext  (lane_rdata_s)
    );

    // Access FSM with request latching, timeout counting and all registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r      <= LSU_ST_IDLE;
            req_ready_r  <= 1'b1;
            we_r         <= 1'b0;
            size_r       <= LSU_SIZE_B;
            zext_r       <= 1'b0;
            off_r        <= '0;
            tmo_cnt_r    <= '0;
            bus_valid_r  <= 1'b0;
            busy_r       <= 1'b0;
            bus_we_r     <= 1'b0;
            bus_addr_r   <= '0;
            bus_be_r     <= '0;
            bus_wdata_r  <= '0;
            resp_valid_r <= 1'b0;
            resp_rdata_r <= '0;
            resp_err_r   <= 1'b0;
        end else begin
            case (state_r)
                LSU_ST_IDLE: begin
                    if (req_valid && req_ready_r) begin
                        req_ready_r <= 1'b0;
                        we_r        <= req_we;
                        size_r      <= size_in_s;
                        zext_r      <= req_unsigned;
                        off_r       <= off_al_s;
                        if (fault_s) begin
                            // Faulting access never reaches the bus.
                            state_r      <= LSU_ST_RESP;
                            resp_valid_r <= 1'b1;
                            resp_err_r   <= 1'b1;
                            resp_rdata_r <= '0;
                        end else begin
                            state_r     <= LSU_ST_BUS;
                            bus_valid_r <= 1'b1;
                            busy_r      <= 1'b1;
                            bus_we_r    <= req_we;
                            bus_addr_r  <= {req_addr[ADDR_W-1:OFF_W], OFF_W'(1'b0)};
                            bus_be_r    <= lane_be_s;
                            bus_wdata_r <= lane_wdata_s;
                            tmo_cnt_r   <= '0;
                        end
                    end
                end
                LSU_ST_BUS: begin
                    if (bus_ack) begin
                        // Ack takes priority over a timeout landing in the same cycle.
                        state_r      <= LSU_ST_RESP;
                        bus_valid_r  <= 1'b0;
                        busy_r       <= 1'b0;
                        bus_be_r     <= '0;
                        resp_valid_r <= 1'b1;
                        resp_err_r   <= 1'b0;
                        resp_rdata_r <= we_r ? '0 : lane_rdata_s;
                    end else if (tmo_cnt_r == CNT_LAST) begin
                        state_r      <= LSU_ST_RESP;
                        bus_valid_r  <= 1'b0;
                        busy_r       <= 1'b0;
                        bus_be_r     <= '0;
                        resp_valid_r <= 1'b1;
                        resp_err_r   <= 1'b1;
                        resp_rdata_r <= '0;
                    end else begin
                        tmo_cnt_r <= tmo_cnt_r + CNT_W'(1'b1);
                    end
                end
                LSU_ST_RESP: begin
                    state_r      <= LSU_ST_IDLE;
                    req_ready_r  <= 1'b1;
                    resp_valid_r <= 1'b0;
                    resp_err_r   <= 1'b0;
                    resp_rdata_r <= '0;
                end
                default: begin
                    state_r      <= LSU_ST_IDLE;
                    req_ready_r  <= 1'b1;
                    bus_valid_r  <= 1'b0;
                    busy_r       <= 1'b0;
                    bus_be_r     <= '0;
                    resp_valid_r <= 1'b0;
                    resp_err_r   <= 1'b0;
                    resp_rdata_r <= '0;
                end
            endcase
        end
    end

    assign req_ready  = req_ready_r;
    assign resp_valid = resp_valid_r;
    assign resp_rdata = resp_rdata_r;
    assign resp_err   = resp_err_r;
    assign busy       = busy_r;
    assign bus_valid  = bus_valid_r;
    assign bus_we     = bus_we_r;
    assign bus_addr   = bus_addr_r;
    assign bus_be     = bus_be_r;
    assign bus_wdata  = bus_wdata_r;

endmodule

// File: tb/tb_riscv_lsu.sv
// Directed bench for riscv_lsu (XLEN=32, TIMEOUT=6). Inputs change and outputs
// are sampled on the falling clock edge.
module tb_riscv_lsu;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic        busy;
    logic        bus_valid;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [3:0]  bus_be;
    logic [31:0] bus_wdata;
    logic        bus_ack;
    logic [31:0] bus_rdata;

    int checks = 0;
    int errors = 0;

    riscv_lsu #(
        .XLEN    (32),
        .ADDR_W  (32),
        .TIMEOUT (6)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_we       (req_we),
        .req_size     (req_size),
        .req_unsigned (req_unsigned),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .resp_valid   (resp_valid),
        .resp_rdata   (resp_rdata),
        .resp_err     (resp_err),
        .busy         (busy),
        .bus_valid    (bus_valid),
        .bus_we       (bus_we),
        .bus_addr     (bus_addr),
        .bus_be       (bus_be),
        .bus_wdata    (bus_wdata),
        .bus_ack      (bus_ack),
        .bus_rdata    (bus_rdata)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Present one request for a single cycle; returns at the falling edge of T+1.
    task automatic issue(input logic we, input logic [1:0] sz, input logic uns,
                         input logic [31:0] addr, input logic [31:0] wd);
        @(negedge clk);
        req_valid    = 1'b1;
        req_we       = we;
        req_size     = sz;
        req_unsigned = uns;
        req_addr     = addr;
        req_wdata    = wd;
        @(negedge clk);
        req_valid    = 1'b0;
    endtask

    // Acknowledge in the current cycle; returns at the falling edge of A+1.
    task automatic ack_now(input logic [31:0] rd);
        bus_ack   = 1'b1;
        bus_rdata = rd;
        @(negedge clk);
        bus_ack   = 1'b0;
    endtask

    initial begin
        rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_size = 2'b00;
        req_unsigned = 1'b0; req_addr = 32'h0; req_wdata = 32'h0;
        bus_ack = 1'b0; bus_rdata = 32'h0;
        repeat (2) @(negedge clk);
        chk("rst_ready", {31'd0, req_ready}, 32'd1);
        chk("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
        chk("rst_rdata", resp_rdata, 32'd0);
        chk("rst_err", {31'd0, resp_err}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_bus_valid", {31'd0, bus_valid}, 32'd0);
        chk("rst_bus_be", {28'd0, bus_be}, 32'd0);
        rst = 1'b0;

        // LB 0x103 signed
        issue(1'b0, 2'b00, 1'b0, 32'h0000_0103, 32'h0);
        chk("lb_bus_valid", {31'd0, bus_valid}, 32'd1);
        chk("lb_busy", {31'd0, busy}, 32'd1);
        chk("lb_ready_low", {31'd0, req_ready}, 32'd0);
        chk("lb_addr", bus_addr, 32'h0000_0100);
        chk("lb_be", {28'd0, bus_be}, 32'h8);
        chk("lb_we", {31'd0, bus_we}, 32'd0);
        ack_now(32'h80FF_0000);
        chk("lb_resp_valid", {31'd0, resp_valid}, 32'd1);
        chk("lb_rdata", resp_rdata, 32'hFFFF_FF80);
        chk("lb_err", {31'd0, resp_err}, 32'd0);
        chk("lb_busy_done", {31'd0, busy}, 32'd0);
        chk("lb_bus_valid_done", {31'd0, bus_valid}, 32'd0);
        @(negedge clk);
        chk("lb_resp_pulse", {31'd0, resp_valid}, 32'd0);
        chk("lb_ready_back", {31'd0, req_ready}, 32'd1);

        // LBU 0x103
        issue(1'b0, 2'b00, 1'b1, 32'h0000_0103, 32'h0);
        ack_now(32'h80FF_0000);
        chk("lbu_resp_valid", {31'd0, resp_valid}, 32'd1);
        chk("lbu_rdata", resp_rdata, 32'h0000_0080);

        // SH 0x102
        issue(1'b1, 2'b01, 1'b0, 32'h0000_0102, 32'h0000_ABCD);
        chk("sh_be", {28'd0, bus_be}, 32'hC);
        chk("sh_wdata", bus_wdata, 32'hABCD_ABCD);
        chk("sh_addr", bus_addr, 32'h0000_0100);
        chk("sh_we", {31'd0, bus_we}, 32'd1);
        ack_now(32'hDEAD_BEEF);
        chk("sh_resp_valid", {31'd0, resp_valid}, 32'd1);
        chk("sh_err", {31'd0, resp_err}, 32'd0);
        chk("sh_rdata_zero", resp_rdata, 32'd0);

        // SB 0x001
        issue(1'b1, 2'b00, 1'b0, 32'h0000_0001, 32'h1234_5678);
        chk("sb_be", {28'd0, bus_be}, 32'h2);
        chk("sb_wdata", bus_wdata, 32'h7878_7878);
        chk("sb_addr", bus_addr, 32'h0000_0000);
        ack_now(32'h0);
        chk("sb_resp_valid", {31'd0, resp_valid}, 32'd1);

        // LW 0x200, ack in the sixth bus cycle (also the timeout cycle: ack wins);
        // a competing request is held meanwhile and must be ignored.
        issue(1'b0, 2'b10, 1'b0, 32'h0000_0200, 32'h0);
        req_valid = 1'b1;
        req_addr  = 32'h0000_0999;
        for (int i = 0; i < 5; i++) begin
            chk("lwd_bus_valid", {31'd0, bus_valid}, 32'd1);
            chk("lwd_busy", {31'd0, busy}, 32'd1);
            chk("lwd_addr", bus_addr, 32'h0000_0200);
            chk("lwd_be", {28'd0, bus_be}, 32'hF);
            chk("lwd_no_resp", {31'd0, resp_valid}, 32'd0);
            @(negedge clk);
        end
        chk("lwd_bus_valid_last", {31'd0, bus_valid}, 32'd1);
        chk("lwd_addr_last", bus_addr, 32'h0000_0200);
        req_valid = 1'b0;
        ack_now(32'h8765_4321);
        chk("lwd_resp_valid", {31'd0, resp_valid}, 32'd1);
        chk("lwd_err", {31'd0, resp_err}, 32'd0);
        chk("lwd_rdata", resp_rdata, 32'h8765_4321);
        chk("lwd_bus_valid_done", {31'd0, bus_valid}, 32'd0);
        @(negedge clk);
        chk("lwd_resp_once", {31'd0, resp_valid}, 32'd0);

        // Timeout: no ack for six bus cycles.
        issue(1'b0, 2'b10, 1'b0, 32'h0000_0300, 32'h0);
        for (int i = 0; i < 6; i++) begin
            chk("tmo_bus_valid", {31'd0, bus_valid}, 32'd1);
            chk("tmo_no_resp", {31'd0, resp_valid}, 32'd0);
            @(negedge clk);
        end
        chk("tmo_bus_valid_drop", {31'd0, bus_valid}, 32'd0);
        chk("tmo_resp_valid", {31'd0, resp_valid}, 32'd1);
        chk("tmo_err", {31'd0, resp_err}, 32'd1);
        chk("tmo_rdata", resp_rdata, 32'd0);
        bus_ack   = 1'b1;
        bus_rdata = 32'hFFFF_FFFF;
        @(negedge clk);
        chk("stray_no_resp", {31'd0, resp_valid}, 32'd0);
        chk("stray_ready", {31'd0, req_ready}, 32'd1);
        chk("stray_bus_idle", {31'd0, bus_valid}, 32'd0);
        @(negedge clk);
        bus_ack = 1'b0;
        chk("stray_no_resp2", {31'd0, resp_valid}, 32'd0);

        // LH 0x402 signed after the timeout
        issue(1'b0, 2'b01, 1'b0, 32'h0000_0402, 32'h0);
        chk("lh_bus_valid", {31'd0, bus_valid}, 32'd1);
        chk("lh_be", {28'd0, bus_be}, 32'hC);
        ack_now(32'h8001_0000);
        chk("lh_resp_valid", {31'd0, resp_valid}, 32'd1);
        chk("lh_rdata", resp_rdata, 32'hFFFF_8001);
        chk("lh_err", {31'd0, resp_err}, 32'd0);

        // Misaligned LW 0x101
        issue(1'b0, 2'b10, 1'b0, 32'h0000_0101, 32'h0);
`ifdef LSU_MISALIGN_TRAP_EN
        chk("mis_no_bus", {31'd0, bus_valid}, 32'd0);
        chk("mis_resp_valid", {31'd0, resp_valid}, 32'd1);
        chk("mis_err", {31'd0, resp_err}, 32'd1);
        @(negedge clk);
`else
        chk("mis_addr", bus_addr, 32'h0000_0100);
        chk("mis_be", {28'd0, bus_be}, 32'hF);
        ack_now(32'h1122_3344);
        chk("mis_resp_valid", {31'd0, resp_valid}, 32'd1);
        chk("mis_err", {31'd0, resp_err}, 32'd0);
        chk("mis_rdata", resp_rdata, 32'h1122_3344);
        @(negedge clk);
`endif

        // Illegal size D on a 32-bit datapath
        issue(1'b0, 2'b11, 1'b0, 32'h0000_0100, 32'h0);
        chk("ild_no_bus", {31'd0, bus_valid}, 32'd0);
        chk("ild_resp_valid", {31'd0, resp_valid}, 32'd1);
        chk("ild_err", {31'd0, resp_err}, 32'd1);
        chk("ild_rdata", resp_rdata, 32'd0);
        @(negedge clk);
        chk("ild_resp_once", {31'd0, resp_valid}, 32'd0);
        chk("ild_ready", {31'd0, req_ready}, 32'd1);

        // Illegal LWU on a 32-bit datapath
        issue(1'b0, 2'b10, 1'b1, 32'h0000_0100, 32'h0);
        chk("ilwu_resp_valid", {31'd0, resp_valid}, 32'd1);
        chk("ilwu_err", {31'd0, resp_err}, 32'd1);
        chk("ilwu_no_bus", {31'd0, bus_valid}, 32'd0);
        @(negedge clk);

        // Reset while the bus is waiting
        issue(1'b0, 2'b10, 1'b0, 32'h0000_0500, 32'h0);
        chk("rmid_bus_valid", {31'd0, bus_valid}, 32'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("rmid_bus_drop", {31'd0, bus_valid}, 32'd0);
        chk("rmid_ready", {31'd0, req_ready}, 32'd1);
        chk("rmid_no_resp", {31'd0, resp_valid}, 32'd0);
        chk("rmid_busy", {31'd0, busy}, 32'd0);
        bus_ack = 1'b1;
        @(negedge clk);
        bus_ack = 1'b0;
        chk("rmid_late_ack", {31'd0, resp_valid}, 32'd0);
        @(negedge clk);
        chk("rmid_late_ack2", {31'd0, resp_valid}, 32'd0);
        chk("rmid_bus_idle", {31'd0, bus_valid}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
